oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_if.sv | 25 ++
 rtl/oam_dma.sv | 123 ++++++++++++
 tb/tb_oam_dma.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus bundle for the OAM DMA block.
// The master modport is the DMA's view; slave is the surrounding system's view.
interface oam_dma_if;
    logic [15:0] A_cpu;
    logic [7:0]  Di_cpu;
    logic [7:0]  Do_cpu;
    logic        rd_cpu_n;
    logic        wr_cpu_n;
    logic [15:0] A_mem;
    logic [7:0]  Do_mem;
    logic [7:0]  Di_mem;
    logic        rd_mem_n;
    logic        wr_mem_n;
    logic        dma_active;

    modport master (
        input  A_cpu, Di_cpu, rd_cpu_n, wr_cpu_n, Di_mem,
        output Do_cpu, A_mem, Do_mem, rd_mem_n, wr_mem_n, dma_active
    );

    modport slave (
        output A_cpu, Di_cpu, rd_cpu_n, wr_cpu_n, Di_mem,
        input  Do_cpu, A_mem, Do_mem, rd_mem_n, wr_mem_n, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies 160 bytes from {page,00} to FE00 when the CPU writes FF46.
// Define OAM_DMA_START_DELAY_EN to add a 4-clock DELAY state before the first READ.
module oam_dma (
    input  logic       clock,
    input  logic       reset,
    oam_dma_if.master  bus
);

`ifdef OAM_DMA_START_DELAY_EN
    typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;
    localparam state_t START_STATE = DELAY;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam state_t START_STATE = READ;
`endif

    localparam logic [7:0] LAST_IDX = 8'd159;

    state_t      state;
    state_t      next_state;
    logic [7:0]  src_reg;
    logic [7:0]  idx;
    logic [7:0]  data_reg;
    logic [7:0]  page;
    logic        ff46_wr;
    logic        ff46_rd;
    logic        hram_hit;
`ifdef OAM_DMA_START_DELAY_EN
    logic [1:0]  delay_cnt;
`endif

    assign ff46_wr  = !bus.wr_cpu_n && (bus.A_cpu == 16'hFF46);
    assign ff46_rd  = !bus.rd_cpu_n && (bus.A_cpu == 16'hFF46);
    assign hram_hit = (bus.A_cpu >= 16'hFF80) && (bus.A_cpu <= 16'hFFFE);
    // Sources at E0 and above alias onto the C0-DF work-RAM pages.
    assign page     = (src_reg >= 8'hE0) ? (src_reg & 8'hDF) : src_reg;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            src_reg   <= 8'h00;
            idx       <= 8'd0;
            data_reg  <= 8'h00;
`ifdef OAM_DMA_START_DELAY_EN
            delay_cnt <= 2'd0;
`endif
        end else if (ff46_wr) begin
            src_reg   <= bus.Di_cpu;
            idx       <= 8'd0;
`ifdef OAM_DMA_START_DELAY_EN
            delay_cnt <= 2'd0;
`endif
        end else begin
            case (state)
`ifdef OAM_DMA_START_DELAY_EN
                DELAY:   delay_cnt <= delay_cnt + 2'd1;
`endif
                READ:    data_reg  <= bus.Di_mem;
                WRITE:   idx       <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
                default: ;
            endcase
        end
    end

    // An FF46 write restarts the transfer from any state, including mid-copy.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = IDLE;
`ifdef OAM_DMA_START_DELAY_EN
            DELAY:   if (delay_cnt == 2'd3) next_state = READ;
`endif
            READ:    next_state = WRITE;
            WRITE:   next_state = (idx == LAST_IDX) ? IDLE : READ;
            default: next_state = IDLE;
        endcase
        if (ff46_wr) next_state = START_STATE;
    end

    always_comb begin
        bus.A_mem      = bus.A_cpu;
        bus.Do_mem     = bus.Di_cpu;
        bus.rd_mem_n   = bus.rd_cpu_n;
        bus.wr_mem_n   = bus.wr_cpu_n;
        bus.dma_active = 1'b0;
        case (state)
`ifdef OAM_DMA_START_DELAY_EN
            DELAY: begin
                bus.A_mem      = {8'hFE, idx};
                bus.Do_mem     = data_reg;
                bus.rd_mem_n   = 1'b1;
                bus.wr_mem_n   = 1'b1;
                bus.dma_active = 1'b1;
            end
`endif
            READ: begin
                bus.A_mem      = {page, idx};
                bus.Do_mem     = data_reg;
                bus.rd_mem_n   = 1'b0;
                bus.wr_mem_n   = 1'b1;
                bus.dma_active = 1'b1;
            end
            WRITE: begin
                bus.A_mem      = {8'hFE, idx};
                bus.Do_mem     = data_reg;
                bus.rd_mem_n   = 1'b1;
                bus.wr_mem_n   = 1'b0;
                bus.dma_active = 1'b1;
            end
            default: ;
        endcase

        // During DMA only HRAM stays visible; everything else reads as FF.
        if (ff46_rd)                          bus.Do_cpu = src_reg;
        else if (state != IDLE && !hram_hit)  bus.Do_cpu = 8'hFF;
        else                                  bus.Do_cpu = bus.Di_mem;
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: timeline-based reference model, memory
// controller with separate HRAM decode, directed scenarios and random traffic.
module tb_oam_dma;

`ifdef OAM_DMA_START_DELAY_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    oam_dma_if bus ();

    oam_dma u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:65535];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'h0000;
    logic [7:0]  bd_data = 8'h00;

    function automatic bit is_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    // Memory controller: HRAM is decoded straight from the CPU bus.
    assign bus.Di_mem = (is_hram(bus.A_cpu) && !bus.rd_cpu_n) ? mem[bus.A_cpu] : mem[bus.A_mem];

    always @(posedge clock) begin
        if (!bus.wr_mem_n && !is_hram(bus.A_mem)) mem[bus.A_mem] <= bus.Do_mem;
        if (!bus.wr_cpu_n && is_hram(bus.A_cpu))  mem[bus.A_cpu] <= bus.Di_cpu;
        if (bd_we)                                mem[bd_addr]   <= bd_data;
    end

    // Reference model: a transfer is just a start cycle plus a source byte.
    int         cyc       = 0;
    int         m_start   = 0;
    bit         m_started = 1'b0;
    logic [7:0] m_src     = 8'h00;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_started <= 1'b0;
            m_src     <= 8'h00;
        end else if (!bus.wr_cpu_n && bus.A_cpu == 16'hFF46) begin
            m_started <= 1'b1;
            m_src     <= bus.Di_cpu;
            m_start   <= cyc + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        int         e;
        int         k;
        int         bidx;
        bit         act;
        bit         dly;
        bit         rdph;
        logic [7:0] pg;
        logic [7:0] bi8;
        if (cyc >= 2) begin
            e    = cyc - m_start;
            act  = m_started && (e >= 0) && (e < D + 320);
            dly  = act && (e < D);
            k    = e - D;
            bidx = k / 2;
            bi8  = bidx[7:0];
            rdph = (k % 2) == 0;
            pg   = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
            check_output("dma_active", bus.dma_active, act);
            if (!act) begin
                check_output("idle_A_mem",    bus.A_mem,    bus.A_cpu);
                check_output("idle_Do_mem",   bus.Do_mem,   bus.Di_cpu);
                check_output("idle_rd_mem_n", bus.rd_mem_n, bus.rd_cpu_n);
                check_output("idle_wr_mem_n", bus.wr_mem_n, bus.wr_cpu_n);
            end else if (dly) begin
                check_output("delay_rd_mem_n", bus.rd_mem_n, 1'b1);
                check_output("delay_wr_mem_n", bus.wr_mem_n, 1'b1);
            end else if (rdph) begin
                check_output("read_A_mem",    bus.A_mem,    {pg, bi8});
                check_output("read_rd_mem_n", bus.rd_mem_n, 1'b0);
                check_output("read_wr_mem_n", bus.wr_mem_n, 1'b1);
            end else begin
                check_output("write_A_mem",    bus.A_mem,    16'hFE00 + bidx);
                check_output("write_Do_mem",   bus.Do_mem,   mem[{pg, bi8}]);
                check_output("write_rd_mem_n", bus.rd_mem_n, 1'b1);
                check_output("write_wr_mem_n", bus.wr_mem_n, 1'b0);
            end
            if (!bus.rd_cpu_n && bus.A_cpu == 16'hFF46)
                check_output("Do_cpu_ff46", bus.Do_cpu, m_src);
            else if (!act)
                check_output("Do_cpu_idle", bus.Do_cpu, bus.Di_mem);
            else if (!bus.rd_cpu_n)
                check_output("Do_cpu_dma", bus.Do_cpu, is_hram(bus.A_cpu) ? bus.Di_mem : 8'hFF);
        end
    end

    task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d, input logic rdn, input logic wrn);
        bus.A_cpu    = a;
        bus.Di_cpu   = d;
        bus.rd_cpu_n = rdn;
        bus.wr_cpu_n = wrn;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic random_op();
        int          sel;
        logic [15:0] a;
        sel = $urandom_range(0, 9);
        a   = 16'($urandom_range(0, 16'hFF7F));
        if (a == 16'hFF46) a = 16'h0000;
        case (sel)
            4, 5: apply_stimulus(a, 8'h00, 1'b0, 1'b1);
            6:    apply_stimulus(a, 8'($urandom), 1'b1, 1'b0);
            7:    apply_stimulus(16'hFF46, 8'h00, 1'b0, 1'b1);
            8:    apply_stimulus(16'hFF80 + 16'($urandom_range(0, 126)), 8'($urandom), 1'b1, 1'b0);
            9:    if ($urandom_range(0, 19) == 0) apply_stimulus(16'hFF46, 8'($urandom), 1'b1, 1'b0);
                  else apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
            default: apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
        endcase
        tick();
    endtask

    logic [7:0] exp_c1 [0:159];
    int         act_cnt;

    initial begin
        reset = 1'b1;
        apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
        repeat (3) tick();
        reset = 1'b0;

        apply_stimulus(16'hFF46, 8'h00, 1'b0, 1'b1);
        check_output("reset_dma_active", bus.dma_active, 1'b0);
        check_output("reset_src_read", bus.Do_cpu, 8'h00);
        tick();

        poke(16'h0150, 8'hA5);
        apply_stimulus(16'h0150, 8'h00, 1'b0, 1'b1);
        check_output("passthru_rd_data", bus.Do_cpu, 8'hA5);
        check_output("passthru_rd_addr", bus.A_mem, 16'h0150);
        tick();

        // Full transfer from C0 with CPU traffic while it runs.
        for (int i = 0; i < 160; i++) poke(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
        apply_stimulus(16'hFF46, 8'hC0, 1'b1, 1'b0);
        tick();
        act_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == 0) begin
                apply_stimulus(16'h8000, 8'h00, 1'b0, 1'b1);
                check_output("dma_vram_read", bus.Do_cpu, 8'hFF);
            end else if (n == 1) begin
                apply_stimulus(16'hFF80, 8'h33, 1'b1, 1'b0);
            end else if (n == 2) begin
                apply_stimulus(16'hC000, 8'h77, 1'b1, 1'b0);
            end else if (n == D + 5) begin
                apply_stimulus(16'hFF80, 8'h00, 1'b0, 1'b1);
                check_output("dma_hram_read", bus.Do_cpu, 8'h33);
            end else begin
                apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
            end
            if (bus.dma_active) act_cnt++;
            tick();
        end
        check_output("active_len_c0", act_cnt, D + 320);
        for (int i = 0; i < 160; i++) check_output("oam_c0", mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
        check_output("c000_kept", mem[16'hC000], 8'h5A);

        // Source FF aliases to page DF.
        apply_stimulus(16'hFF46, 8'hFF, 1'b1, 1'b0);
        tick();
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
            if (n == D) check_output("first_read_ff", bus.A_mem, 16'hDF00);
            tick();
        end

        // Restart at idx 80 with source C1.
        for (int i = 0; i < 160; i++) begin
            exp_c1[i] = 8'($urandom);
            poke(16'hC100 + 16'(i), exp_c1[i]);
        end
        apply_stimulus(16'hFF46, 8'hC0, 1'b1, 1'b0);
        tick();
        for (int n = 0; n < D + 160; n++) idle_cycle();
        apply_stimulus(16'hFF46, 8'hC1, 1'b1, 1'b0);
        tick();
        act_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1);
            if (n == D) check_output("restart_addr", bus.A_mem, 16'hC100);
            if (bus.dma_active) act_cnt++;
            tick();
        end
        check_output("active_len_restart", act_cnt, D + 320);
        for (int i = 0; i < 160; i++) check_output("oam_c1", mem[16'hFE00 + 16'(i)], exp_c1[i]);

        // Reset during the WRITE of idx 10.
        for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), 8'hEE);
        apply_stimulus(16'hFF46, 8'hC0, 1'b1, 1'b0);
        tick();
        for (int n = 0; n < D + 21; n++) idle_cycle();
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        apply_stimulus(16'hFF46, 8'h00, 1'b0, 1'b1);
        check_output("abort_active", bus.dma_active, 1'b0);
        check_output("abort_src", bus.Do_cpu, 8'h00);
        tick();
        repeat (340) idle_cycle();
        for (int i = 0; i < 10; i++) check_output("oam_before_abort", mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
        for (int i = 11; i < 160; i++) check_output("oam_untouched", mem[16'hFE00 + 16'(i)], 8'hEE);

        // Random sources with random CPU traffic.
        for (int r = 0; r < 6; r++) begin
            apply_stimulus(16'hFF46, 8'($urandom), 1'b1, 1'b0);
            tick();
            for (int n = 0; n < D + 340; n++) random_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
